// File: rtl/shifter_arbiter.sv
// Round-robin arbiter that shares one Shifter between NUM_REQ requesters,
// sequencing the start/done handshake with a timeout watchdog per transaction.
module shifter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_base,
  input  logic [NUM_REQ*WIDTH-1:0]   req_power,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           sh_base,
  output logic [WIDTH-1:0]           sh_power,
  output logic                       sh_start,
  input  logic [WIDTH-1:0]           sh_result,
  input  logic                       sh_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);
  localparam logic [SW-1:0] NREQ_W   = SW'(NUM_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [IW-1:0] last_grant;
  logic [CW-1:0] wd_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_id;
  logic [SW-1:0] cand;

  // Search upward from last_grant+1, wrapping; the extra bit of cand absorbs
  // the overflow before it is folded back into range.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + SW'(i + 1);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!pick_valid && req[cand[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack        <= '0;
      sh_start   <= 1'b0;
      busy       <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      sh_base    <= '0;
      sh_power   <= '0;
      grant_id   <= '0;
      last_grant <= LAST_ID;
      wd_cnt     <= '0;
    end else begin
      ack      <= '0;
      sh_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            sh_base  <= req_base[pick_id*WIDTH +: WIDTH];
            sh_power <= req_power[pick_id*WIDTH +: WIDTH];
            sh_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        // A done arriving on the last watchdog cycle still counts as success.
        WAIT: begin
          if (sh_done) begin
            rsp_result <= sh_result;
            rsp_err    <= 1'b0;
            ack        <= NUM_REQ'(1) << grant_id;
            state      <= RESP;
          end else if (wd_cnt == CNT_LAST) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            ack        <= NUM_REQ'(1) << grant_id;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter with a base<<power Shifter model whose
// done latency is adjustable per scenario.
module tb_shifter_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_base = '0;
  logic [63:0] req_power = '0;
  logic [3:0]  ack;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] sh_base;
  logic [15:0] sh_power;
  logic        sh_start;
  logic [15:0] sh_result = '0;
  logic        sh_done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_delay = 3;
  int remain = 0;
  int start_count = 0;
  int start_times[$];
  logic [15:0] start_base = '0;
  logic [15:0] start_power = '0;

  shifter_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_base(req_base), .req_power(req_power),
    .ack(ack), .rsp_result(rsp_result), .rsp_err(rsp_err), .grant_id(grant_id),
    .busy(busy), .sh_base(sh_base), .sh_power(sh_power), .sh_start(sh_start),
    .sh_result(sh_result), .sh_done(sh_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shifter model: done_delay of 0 means done never comes.
  always @(posedge clk) begin
    if (sh_start) begin
      remain    <= done_delay;
      sh_result <= sh_base << sh_power;
    end else if (remain > 0) begin
      remain <= remain - 1;
    end
  end
  assign sh_done = (remain == 1);

  always @(negedge clk) begin
    if (sh_start) begin
      start_count++;
      start_times.push_back(cyc);
      start_base  = sh_base;
      start_power = sh_power;
    end
  end

  task automatic wait_ack(input int limit, output int cycles, output logic [3:0] a,
                          output logic [15:0] r, output logic e, output logic [1:0] g);
    cycles = 0; a = '0; r = '0; e = 1'b0; g = '0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (ack !== 4'b0000) begin
        a = ack; r = rsp_result; e = rsp_err; g = grant_id;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; req_base = '0; req_power = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    compared++; if (ack !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ack: got %0h expected 0", ack); end
    compared++; if (sh_start !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_start: got %0h expected 0", sh_start); end
    compared++; if ({rsp_err, rsp_result} !== 17'h0) begin mismatched++; $display("[TB] FAIL reset_rsp: got %0h expected 0", {rsp_err, rsp_result}); end
    compared++; if ({sh_base, sh_power, grant_id} !== 34'h0) begin mismatched++; $display("[TB] FAIL reset_operands: got %0h expected 0", {sh_base, sh_power, grant_id}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_no_req: got busy %0h expected 0", busy); end
  endtask

  task automatic test_single();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g; int n0;
    req_base[47:32] = 16'h0003; req_power[47:32] = 16'd4;
    n0 = start_count;
    req = 4'b0100;
    @(posedge clk); #1;
    req_base[47:32] = 16'hFFFF; req_power[47:32] = 16'd0;
    compared++; if ({sh_start, busy, grant_id} !== {1'b1, 1'b1, 2'd2}) begin mismatched++; $display("[TB] FAIL single_issue: got %0h expected %0h", {sh_start, busy, grant_id}, {1'b1, 1'b1, 2'd2}); end
    @(posedge clk); #1;
    compared++; if (sh_start !== 1'b0) begin mismatched++; $display("[TB] FAIL single_start_width: got %0h expected 0", sh_start); end
    wait_ack(20, n, a, r, e, g);
    compared++; if (a !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_ack: got %0h expected 4", a); end
    compared++; if (r !== 16'h0030) begin mismatched++; $display("[TB] FAIL single_result: got %0h expected 30", r); end
    compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL single_err: got %0h expected 0", e); end
    compared++; if (n !== 3) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 3", n); end
    compared++; if ({sh_base, sh_power} !== {16'h0003, 16'd4}) begin mismatched++; $display("[TB] FAIL single_operands_held: got %0h expected 30004", {sh_base, sh_power}); end
    compared++; if ({start_base, start_power} !== {16'h0003, 16'd4}) begin mismatched++; $display("[TB] FAIL single_start_operands: got %0h expected 30004", {start_base, start_power}); end
    @(posedge clk); #1;
    req = '0;
    compared++; if ({ack, busy} !== 5'b0) begin mismatched++; $display("[TB] FAIL single_release: got %0h expected 0", {ack, busy}); end
    compared++; if (rsp_result !== 16'h0030) begin mismatched++; $display("[TB] FAIL single_result_hold: got %0h expected 30", rsp_result); end
    repeat (2) @(posedge clk); #1;
    compared++; if (start_count - n0 !== 1) begin mismatched++; $display("[TB] FAIL single_start_count: got %0d expected 1", start_count - n0); end
  endtask

  task automatic test_all_four();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g;
    logic [15:0] exp_res [4] = '{16'h0002, 16'h0014, 16'hFF00, 16'h0002};
    pulse_reset();
    done_delay = 3;
    req_base  = {16'h8001, 16'h00FF, 16'h0005, 16'h0001};
    req_power = {16'd1,    16'd8,    16'd2,    16'd1};
    start_times.delete();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(30, n, a, r, e, g);
      compared++; if (a !== (4'b0001 << k)) begin mismatched++; $display("[TB] FAIL all4_ack%0d: got %0h expected %0h", k, a, 4'b0001 << k); end
      compared++; if ({e, r} !== {1'b0, exp_res[k]}) begin mismatched++; $display("[TB] FAIL all4_result%0d: got %0h expected %0h", k, {e, r}, exp_res[k]); end
      @(posedge clk); #1;
      req[k] = 1'b0;
    end
    compared++; if (start_times.size() !== 4) begin mismatched++; $display("[TB] FAIL all4_starts: got %0d expected 4", start_times.size()); end
    for (int k = 1; k < 4; k++) begin
      compared++; if (start_times[k] - start_times[k-1] !== 6) begin mismatched++; $display("[TB] FAIL all4_gap%0d: got %0d expected 6", k, start_times[k] - start_times[k-1]); end
    end
  endtask

  task automatic test_fairness();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g; logic [1:0] exp_id; logic [15:0] exp_r;
    req_base[15:0]  = 16'h00A5; req_power[15:0]  = 16'd0;
    req_base[63:48] = 16'h0001; req_power[63:48] = 16'd15;
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0) ? 2'd0 : 2'd3;
      exp_r  = (k % 2 == 0) ? 16'h00A5 : 16'h8000;
      wait_ack(30, n, a, r, e, g);
      compared++; if ({a, g} !== {4'b0001 << exp_id, exp_id}) begin mismatched++; $display("[TB] FAIL fair_grant%0d: got ack %0h id %0d expected id %0d", k, a, g, exp_id); end
      compared++; if (r !== exp_r) begin mismatched++; $display("[TB] FAIL fair_result%0d: got %0h expected %0h", k, r, exp_r); end
      @(posedge clk); #1;
      if (exp_id == 2'd0) begin
        req[0] = 1'b0;
        @(posedge clk); #1;
        req[0] = 1'b1;
      end
    end
    req = '0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g;
    done_delay = 0;
    req_base[31:16] = 16'h0007; req_power[31:16] = 16'd2;
    req = 4'b0010;
    wait_ack(20, n, a, r, e, g);
    compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL timeout_latency: got %0d expected 10", n); end
    compared++; if ({a, e, r} !== {4'b0010, 1'b1, 16'h0000}) begin mismatched++; $display("[TB] FAIL timeout_rsp: got %0h expected %0h", {a, e, r}, {4'b0010, 1'b1, 16'h0000}); end
    @(posedge clk); #1;
    req = '0;
    compared++; if ({ack, rsp_err} !== 5'b00001) begin mismatched++; $display("[TB] FAIL timeout_err_hold: got %0h expected 1", {ack, rsp_err}); end
    done_delay = 3;
    req_base[47:32] = 16'h0009; req_power[47:32] = 16'd3;
    req = 4'b0100;
    wait_ack(20, n, a, r, e, g);
    compared++; if ({a, e, r} !== {4'b0100, 1'b0, 16'h0048}) begin mismatched++; $display("[TB] FAIL after_timeout: got %0h expected %0h", {a, e, r}, {4'b0100, 1'b0, 16'h0048}); end
    compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL after_timeout_latency: got %0d expected 5", n); end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_req_drop();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g;
    req_base[63:48] = 16'h0101; req_power[63:48] = 16'd1;
    req = 4'b1000;
    repeat (2) @(posedge clk); #1;
    req = '0;
    wait_ack(20, n, a, r, e, g);
    compared++; if ({a, e, r} !== {4'b1000, 1'b0, 16'h0202}) begin mismatched++; $display("[TB] FAIL req_drop: got %0h expected %0h", {a, e, r}, {4'b1000, 1'b0, 16'h0202}); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g; logic [3:0] seen;
    done_delay = 3;
    req_base[63:48] = 16'h0002; req_power[63:48] = 16'd1;
    req = 4'b1000;
    @(posedge clk); #1;
    compared++; if ({sh_start, grant_id} !== 3'b111) begin mismatched++; $display("[TB] FAIL midreset_issue: got %0h expected 7", {sh_start, grant_id}); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0; req = '0;
    #1;
    compared++; if ({busy, sh_start, ack, grant_id} !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_async: got %0h expected 0", {busy, sh_start, ack, grant_id}); end
    compared++; if ({sh_base, sh_power} !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_operands: got %0h expected 0", {sh_base, sh_power}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = '0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= ack;
      seen[0] |= busy;
    end
    compared++; if (seen !== 4'b0000) begin mismatched++; $display("[TB] FAIL midreset_no_ack: got %0h expected 0", seen); end
    req_base[31:0] = {16'h0004, 16'h0003}; req_power[31:0] = {16'd1, 16'd2};
    req = 4'b0011;
    wait_ack(20, n, a, r, e, g);
    compared++; if ({a, r} !== {4'b0001, 16'h000C}) begin mismatched++; $display("[TB] FAIL midreset_first: got %0h expected %0h", {a, r}, {4'b0001, 16'h000C}); end
    @(posedge clk); #1;
    req[0] = 1'b0;
    wait_ack(20, n, a, r, e, g);
    compared++; if ({a, r} !== {4'b0010, 16'h0008}) begin mismatched++; $display("[TB] FAIL midreset_second: got %0h expected %0h", {a, r}, {4'b0010, 16'h0008}); end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_collision();
    int n; logic [3:0] a; logic [15:0] r; logic e; logic [1:0] g;
    done_delay = TIMEOUT;
    req_base[15:0] = 16'hFFFF; req_power[15:0] = 16'd1;
    req = 4'b0001;
    wait_ack(20, n, a, r, e, g);
    compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL collide_latency: got %0d expected 10", n); end
    compared++; if ({a, e, r} !== {4'b0001, 1'b0, 16'hFFFE}) begin mismatched++; $display("[TB] FAIL collide_rsp: got %0h expected %0h", {a, e, r}, {4'b0001, 1'b0, 16'hFFFE}); end
    @(posedge clk); #1;
    req = '0;
    done_delay = TIMEOUT + 1;
    req_base[47:32] = 16'h1111; req_power[47:32] = 16'd0;
    req = 4'b0100;
    wait_ack(20, n, a, r, e, g);
    compared++; if ({a, e, r} !== {4'b0100, 1'b1, 16'h0000}) begin mismatched++; $display("[TB] FAIL late_done_rsp: got %0h expected %0h", {a, e, r}, {4'b0100, 1'b1, 16'h0000}); end
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    compared++; if ({busy, ack} !== 5'b0) begin mismatched++; $display("[TB] FAIL late_done_ignored: got %0h expected 0", {busy, ack}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_timeout();
    test_req_drop();
    test_reset_mid_wait();
    test_collision();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
